// File: rtl/memctrl_pkg.sv
// memctrl_pkg: shared types and constants for the parameterised memory controller.
//   state_e      - controller FSM states
//   Mode*        - BIST algorithm select codes (4-7 reserved)
//   op_e/elem_t  - march element encoding: direction plus one or two ops
//   CheckerPat   - checkerboard background, sliced to the data width by the user
package memctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHwr,
        StHrd,
        StBrun,
        StBdone
    } state_e;

    localparam logic [2:0] ModeMarchC  = 3'd0;
    localparam logic [2:0] ModeMats    = 3'd1;
    localparam logic [2:0] ModeChecker = 3'd2;
    localparam logic [2:0] ModeSolid   = 3'd3;

    // bit 1: read, bit 0: inverse background
    typedef enum logic [1:0] {
        OpW0 = 2'b00,
        OpW1 = 2'b01,
        OpR0 = 2'b10,
        OpR1 = 2'b11
    } op_e;

    typedef struct packed {
        logic valid;
        logic down;
        logic two;
        op_e  op0;
        op_e  op1;
    } elem_t;

    // 0x55.. background; supports data widths up to 64 bits
    localparam logic [63:0] CheckerPat = {32{2'b01}};

    function automatic elem_t mk_elem(logic down, logic two, op_e op0, op_e op1);
        elem_t e;
        e.valid = 1'b1;
        e.down  = down;
        e.two   = two;
        e.op0   = op0;
        e.op1   = op1;
        return e;
    endfunction

    // Element table; an invalid element marks the end of the algorithm.
    function automatic elem_t march_elem(logic [2:0] mode, logic [2:0] idx);
        elem_t e;
        e = '0;
        case (mode)
            ModeMarchC: begin
                case (idx)
                    3'd0: e = mk_elem(1'b0, 1'b0, OpW0, OpW0);
                    3'd1: e = mk_elem(1'b0, 1'b1, OpR0, OpW1);
                    3'd2: e = mk_elem(1'b0, 1'b1, OpR1, OpW0);
                    3'd3: e = mk_elem(1'b1, 1'b1, OpR0, OpW1);
                    3'd4: e = mk_elem(1'b1, 1'b1, OpR1, OpW0);
                    3'd5: e = mk_elem(1'b0, 1'b0, OpR0, OpR0);
                    default: e = '0;
                endcase
            end
            ModeMats: begin
                case (idx)
                    3'd0: e = mk_elem(1'b0, 1'b0, OpW0, OpW0);
                    3'd1: e = mk_elem(1'b0, 1'b1, OpR0, OpW1);
                    3'd2: e = mk_elem(1'b1, 1'b1, OpR1, OpW0);
                    default: e = '0;
                endcase
            end
            ModeChecker, ModeSolid: begin
                case (idx)
                    3'd0: e = mk_elem(1'b0, 1'b0, OpW0, OpW0);
                    3'd1: e = mk_elem(1'b0, 1'b0, OpR0, OpR0);
                    3'd2: e = mk_elem(1'b0, 1'b0, OpW1, OpW1);
                    3'd3: e = mk_elem(1'b0, 1'b0, OpR1, OpR1);
                    default: e = '0;
                endcase
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic elem_down(logic [2:0] mode, logic [2:0] idx);
        elem_t e;
        e = march_elem(mode, idx);
        return e.down;
    endfunction

    function automatic logic op_is_read(op_e op);
        return (op == OpR0) || (op == OpR1);
    endfunction

    function automatic logic op_inv(op_e op);
        return (op == OpW1) || (op == OpR1);
    endfunction

endpackage

// File: rtl/memctrl_sram.sv
// memctrl_sram: single-port 2^AW x DW storage, synchronous read (1-cycle latency), no reset.
//   CLK      - clock, rising edge
//   en_i     - access enable
//   we_i     - 1 = write, 0 = read
//   addr_i   - word address
//   wdata_i  - write data
//   rdata_o  - read data, updated only by reads
module memctrl_sram #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8
) (
    input  logic          CLK,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge CLK) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/memctrl_param.sv
// memctrl_param: host-accessed memory controller with built-in self test.
//   CLK, RSTN            - clock (rising edge), asynchronous active-low reset
//   CE, CSB, WEB, ADDR,  - host command: strobe (rising level), chip select,
//   IDATA                  write enable, address, write data
//   OEB, ODATA           - output enable (active-low) and read data
//   BIST_EN, BIST_MODE   - BIST start (rise) / abort (low), algorithm select
//   FAULT_INJ            - inverts bit 0 of read data from FI_ADDR
//   BIST_PASS, BIST_DONE,
//   BIST_FAIL_ADDR       - BIST result, completion, first failing address
module memctrl_param
    import memctrl_pkg::*;
#(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 8,
    parameter int unsigned FI_ADDR = 0
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CE,
    input  logic          CSB,
    input  logic          WEB,
    input  logic          OEB,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] IDATA,
    input  logic          BIST_EN,
    input  logic [2:0]    BIST_MODE,
    input  logic          FAULT_INJ,
    output logic [DW-1:0] ODATA,
    output logic          BIST_PASS,
    output logic          BIST_DONE,
    output logic [AW-1:0] BIST_FAIL_ADDR
);

    localparam logic [DW-1:0] CheckerD = CheckerPat[DW-1:0];
    localparam logic [AW-1:0] FiAddr   = AW'(FI_ADDR);
    localparam logic [AW-1:0] AddrMax  = {AW{1'b1}};

    state_e        state_q, state_d;
    logic          ce_q, bist_en_q;
    logic          cmd, bist_rise;
    logic [AW-1:0] haddr_q, haddr_d;
    logic [DW-1:0] hdata_q, hdata_d;
    logic          rd_pend_q, rd_pend_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [2:0]    mode_q, mode_d;
    logic [2:0]    elem_q, elem_d;
    logic          opi_q, opi_d;
    logic [AW-1:0] baddr_q, baddr_d;
    logic          cmp_valid_q, cmp_valid_d;
    logic [DW-1:0] cmp_exp_q, cmp_exp_d;
    logic [AW-1:0] cmp_addr_q, cmp_addr_d;
    logic          fail_seen_q, fail_seen_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [AW-1:0] rd_addr_q;

    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata, rdata_fi;

    elem_t         cur;
    op_e           cur_op;
    logic [DW-1:0] pat_base, op_data;
    logic          last_addr;

    memctrl_sram #(
        .AW(AW),
        .DW(DW)
    ) u_sram (
        .CLK    (CLK),
        .en_i   (sram_en),
        .we_i   (sram_we),
        .addr_i (sram_addr),
        .wdata_i(sram_wdata),
        .rdata_o(sram_rdata)
    );

    assign cmd       = CE & ~ce_q;
    assign bist_rise = BIST_EN & ~bist_en_q;

    // Fault injection tracks the address of the word currently on the read port.
    assign rdata_fi = sram_rdata ^ {{(DW-1){1'b0}}, FAULT_INJ && (rd_addr_q == FiAddr)};

    assign cur       = march_elem(mode_q, elem_q);
    assign cur_op    = opi_q ? cur.op1 : cur.op0;
    assign pat_base  = (mode_q == ModeChecker) ? CheckerD : '0;
    assign op_data   = op_inv(cur_op) ? ~pat_base : pat_base;
    assign last_addr = cur.down ? (baddr_q == '0) : (baddr_q == AddrMax);

    assign ODATA          = OEB ? '0 : hold_q;
    assign BIST_DONE      = (state_q == StBdone);
    assign BIST_PASS      = (state_q == StBdone) && !fail_seen_q;
    assign BIST_FAIL_ADDR = fail_addr_q;

    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hdata_d     = hdata_q;
        rd_pend_d   = 1'b0;
        hold_d      = rd_pend_q ? rdata_fi : hold_q;
        mode_d      = mode_q;
        elem_d      = elem_q;
        opi_d       = opi_q;
        baddr_d     = baddr_q;
        cmp_valid_d = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        fail_seen_d = fail_seen_q;
        fail_addr_d = fail_addr_q;
        sram_en     = 1'b0;
        sram_we     = 1'b0;
        sram_addr   = haddr_q;
        sram_wdata  = hdata_q;

        // Compare trails the BIST read by one cycle; only the first miss is kept.
        if (state_q == StBrun && cmp_valid_q && rdata_fi != cmp_exp_q && !fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_addr_d = cmp_addr_q;
        end

        unique case (state_q)
            StIdle: begin
                if (bist_rise) begin
                    mode_d      = BIST_MODE;
                    elem_d      = 3'd0;
                    opi_d       = 1'b0;
                    baddr_d     = elem_down(BIST_MODE, 3'd0) ? AddrMax : '0;
                    fail_addr_d = '0;
                    // Reserved modes finish at once and report failure.
                    fail_seen_d = BIST_MODE[2];
                    state_d     = BIST_MODE[2] ? StBdone : StBrun;
                end else if (cmd && !CSB) begin
                    haddr_d = ADDR;
                    hdata_d = IDATA;
                    state_d = WEB ? StHrd : StHwr;
                end
            end
            StHwr: begin
                sram_en = 1'b1;
                sram_we = 1'b1;
                state_d = StIdle;
            end
            StHrd: begin
                sram_en   = 1'b1;
                rd_pend_d = 1'b1;
                state_d   = StIdle;
            end
            StBrun: begin
                if (!BIST_EN) begin
                    state_d = StIdle;
                end else if (cur.valid) begin
                    sram_en    = 1'b1;
                    sram_we    = !op_is_read(cur_op);
                    sram_addr  = baddr_q;
                    sram_wdata = op_data;
                    if (op_is_read(cur_op)) begin
                        cmp_valid_d = 1'b1;
                        cmp_exp_d   = op_data;
                        cmp_addr_d  = baddr_q;
                    end
                    if (cur.two && !opi_q) begin
                        opi_d = 1'b1;
                    end else begin
                        opi_d = 1'b0;
                        if (last_addr) begin
                            elem_d  = elem_q + 3'd1;
                            baddr_d = elem_down(mode_q, elem_q + 3'd1) ? AddrMax : '0;
                        end else begin
                            baddr_d = cur.down ? baddr_q - AW'(1) : baddr_q + AW'(1);
                        end
                    end
                end else begin
                    state_d = StBdone;
                end
            end
            StBdone: begin
                if (!BIST_EN) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= StIdle;
            ce_q        <= 1'b0;
            bist_en_q   <= 1'b0;
            haddr_q     <= '0;
            hdata_q     <= '0;
            rd_pend_q   <= 1'b0;
            hold_q      <= '0;
            mode_q      <= '0;
            elem_q      <= '0;
            opi_q       <= 1'b0;
            baddr_q     <= '0;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            fail_seen_q <= 1'b0;
            fail_addr_q <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            ce_q        <= CE;
            bist_en_q   <= BIST_EN;
            haddr_q     <= haddr_d;
            hdata_q     <= hdata_d;
            rd_pend_q   <= rd_pend_d;
            hold_q      <= hold_d;
            mode_q      <= mode_d;
            elem_q      <= elem_d;
            opi_q       <= opi_d;
            baddr_q     <= baddr_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            fail_seen_q <= fail_seen_d;
            fail_addr_q <= fail_addr_d;
            if (sram_en && !sram_we) begin
                rd_addr_q <= sram_addr;
            end
        end
    end

endmodule

// File: tb/tb_memctrl_param.sv
// tb_memctrl_param: directed self-checking bench for memctrl_param (AW=4, DW=8, FI_ADDR=9).
module tb_memctrl_param;

    logic       CLK, RSTN, CE, CSB, WEB, OEB, BIST_EN, FAULT_INJ;
    logic [3:0] ADDR;
    logic [7:0] IDATA;
    logic [2:0] BIST_MODE;
    logic [7:0] ODATA;
    logic       BIST_PASS, BIST_DONE;
    logic [3:0] BIST_FAIL_ADDR;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] tb_mem [16];
    logic [7:0] exp_q [$];
    logic [7:0] hold_m;
    int         n;

    memctrl_param #(
        .AW     (4),
        .DW     (8),
        .FI_ADDR(9)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .CE            (CE),
        .CSB           (CSB),
        .WEB           (WEB),
        .OEB           (OEB),
        .ADDR          (ADDR),
        .IDATA         (IDATA),
        .BIST_EN       (BIST_EN),
        .BIST_MODE     (BIST_MODE),
        .FAULT_INJ     (FAULT_INJ),
        .ODATA         (ODATA),
        .BIST_PASS     (BIST_PASS),
        .BIST_DONE     (BIST_DONE),
        .BIST_FAIL_ADDR(BIST_FAIL_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One host command: strobe for one edge, then idle two edges. Reads are pushed to the
    // scoreboard at issue and popped when the holding register should have been loaded.
    task automatic host_cmd(input logic csb, input logic web, input logic [3:0] a,
                            input logic [7:0] d, input bit accept);
        CE = 1'b1; CSB = csb; WEB = web; ADDR = a; IDATA = d;
        if (accept && !csb && web) exp_q.push_back(tb_mem[a]);
        tick();
        CE = 1'b0; CSB = 1'b1;
        if (accept && !csb && !web) tb_mem[a] = d;
        tick();
        if (!csb && web) chk("rd_latency_cmd+1", 32'(ODATA), 32'(OEB ? 8'h00 : hold_m));
        tick();
        if (!csb && web) begin
            if (accept && exp_q.size() > 0) hold_m = exp_q.pop_front();
            chk("rd_data_cmd+2", 32'(ODATA), 32'(OEB ? 8'h00 : hold_m));
        end
    endtask

    task automatic wait_done(input int budget, output int cnt);
        cnt = 0;
        while (!BIST_DONE && cnt < budget) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        RSTN = 1'b0; CE = 1'b0; CSB = 1'b1; WEB = 1'b1; OEB = 1'b0; ADDR = '0; IDATA = '0;
        BIST_EN = 1'b0; BIST_MODE = '0; FAULT_INJ = 1'b0; hold_m = 8'h00;
        for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
        tick(); tick();
        chk("rst_odata", 32'(ODATA), 32'h0);
        chk("rst_done", 32'(BIST_DONE), 32'h0);
        chk("rst_pass", 32'(BIST_PASS), 32'h0);
        chk("rst_fail_addr", 32'(BIST_FAIL_ADDR), 32'h0);
        RSTN = 1'b1;
        tick(); tick();

        // Basic write/read and output enable
        host_cmd(1'b0, 1'b0, 4'h3, 8'hA5, 1'b1);
        host_cmd(1'b0, 1'b1, 4'h3, 8'h00, 1'b1);
        OEB = 1'b1; #1;
        chk("oeb_high_zero", 32'(ODATA), 32'h0);
        OEB = 1'b0; #1;
        chk("oeb_low_hold", 32'(ODATA), 32'hA5);

        // Address extremes and ignored chip-deselected command
        host_cmd(1'b0, 1'b0, 4'hF, 8'h11, 1'b1);
        host_cmd(1'b0, 1'b0, 4'h0, 8'h22, 1'b1);
        host_cmd(1'b0, 1'b1, 4'hF, 8'h00, 1'b1);
        host_cmd(1'b0, 1'b1, 4'h0, 8'h00, 1'b1);
        host_cmd(1'b1, 1'b0, 4'h0, 8'h77, 1'b1);
        host_cmd(1'b0, 1'b1, 4'h0, 8'h00, 1'b1);

        // CE held high: only the first edge is a command
        CE = 1'b1; CSB = 1'b0; WEB = 1'b0; ADDR = 4'h5; IDATA = 8'h5A;
        tick();
        IDATA = 8'hFF;
        tick(); tick(); tick();
        CE = 1'b0; CSB = 1'b1;
        tb_mem[5] = 8'h5A;
        tick(); tick();
        host_cmd(1'b0, 1'b1, 4'h5, 8'h00, 1'b1);

        // March C-, no fault: passes, leaves memory all zero
        BIST_MODE = 3'd0; BIST_EN = 1'b1;
        tick();
        chk("pass_low_running", 32'(BIST_PASS), 32'h0);
        wait_done(163, n);
        chk("marchc_done", 32'(BIST_DONE), 32'h1);
        chk("marchc_not_early", 32'(n + 1 >= 160), 32'h1);
        chk("marchc_pass", 32'(BIST_PASS), 32'h1);
        BIST_EN = 1'b0;
        tick();
        chk("marchc_done_clr", 32'(BIST_DONE), 32'h0);
        chk("marchc_pass_clr", 32'(BIST_PASS), 32'h0);
        for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
        host_cmd(1'b0, 1'b1, 4'h3, 8'h00, 1'b1);

        // Checkerboard: final background is 0xAA
        BIST_MODE = 3'd2; BIST_EN = 1'b1;
        wait_done(68, n);
        chk("checker_done", 32'(BIST_DONE), 32'h1);
        chk("checker_pass", 32'(BIST_PASS), 32'h1);
        BIST_EN = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) tb_mem[i] = 8'hAA;
        host_cmd(1'b0, 1'b1, 4'h3, 8'h00, 1'b1);

        // MATS+ with injected fault at address 9
        FAULT_INJ = 1'b1; BIST_MODE = 3'd1; BIST_EN = 1'b1;
        wait_done(84, n);
        chk("mats_done", 32'(BIST_DONE), 32'h1);
        chk("mats_fail_pass", 32'(BIST_PASS), 32'h0);
        chk("mats_fail_addr", 32'(BIST_FAIL_ADDR), 32'h9);
        BIST_EN = 1'b0; FAULT_INJ = 1'b0;
        tick();
        chk("mats_done_clr", 32'(BIST_DONE), 32'h0);

        // Reserved mode finishes at once; host commands in BDONE are dropped
        BIST_MODE = 3'd5; BIST_EN = 1'b1;
        wait_done(4, n);
        chk("rsvd_done", 32'(BIST_DONE), 32'h1);
        chk("rsvd_pass", 32'(BIST_PASS), 32'h0);
        chk("rsvd_fail_addr", 32'(BIST_FAIL_ADDR), 32'h0);
        host_cmd(1'b0, 1'b1, 4'h0, 8'h00, 1'b0);
        BIST_EN = 1'b0;
        tick();

        // Host read during BRUN is dropped; abort clears DONE/PASS
        BIST_MODE = 3'd0; BIST_EN = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        host_cmd(1'b0, 1'b1, 4'h1, 8'h00, 1'b0);
        BIST_EN = 1'b0;
        tick();
        chk("abort_done", 32'(BIST_DONE), 32'h0);
        chk("abort_pass", 32'(BIST_PASS), 32'h0);
        tick();

        // Asynchronous reset mid-BIST after a failure has been latched
        FAULT_INJ = 1'b1; BIST_MODE = 3'd1; BIST_EN = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        chk("midbist_fail_addr", 32'(BIST_FAIL_ADDR), 32'h9);
        chk("midbist_odata", 32'(ODATA), 32'(hold_m));
        #2 RSTN = 1'b0;
        #1;
        chk("async_rst_odata", 32'(ODATA), 32'h0);
        chk("async_rst_fail_addr", 32'(BIST_FAIL_ADDR), 32'h0);
        chk("async_rst_done", 32'(BIST_DONE), 32'h0);
        chk("async_rst_pass", 32'(BIST_PASS), 32'h0);
        hold_m = 8'h00;
        BIST_EN = 1'b0; FAULT_INJ = 1'b0;
        tick();
        RSTN = 1'b1;
        tick(); tick();
        host_cmd(1'b0, 1'b0, 4'h7, 8'h3C, 1'b1);
        host_cmd(1'b0, 1'b1, 4'h7, 8'h00, 1'b1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/memctrl_param.md
MEMCTRL_PARAM -- requirements
Module: memctrl_param

Interface
REQ-001 The block SHALL have parameter AW, default 16, meaning address width; memory depth is 2^AW words.
REQ-002 The block SHALL have parameter DW, default 8, meaning data width (even, >=2).
REQ-003 The block SHALL have parameter FI_ADDR, default 0, meaning the address affected by fault injection.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single system clock; all state is rising-edge.
REQ-005 The block SHALL have port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port CE, input, 1 bit: command strobe, synchronous to CLK.
REQ-007 The block SHALL have port CSB, input, 1 bit: chip select, active-low.
REQ-008 The block SHALL have port WEB, input, 1 bit: write enable, active-low.
REQ-009 The block SHALL have port OEB, input, 1 bit: output enable, active-low.
REQ-010 The block SHALL have port ADDR, input, AW bits: host address.
REQ-011 The block SHALL have port IDATA, input, DW bits: host write data.
REQ-012 The block SHALL have port BIST_EN, input, 1 bit: level; a rising edge starts BIST and low aborts it.
REQ-013 The block SHALL have port BIST_MODE, input, 3 bits: algorithm select, sampled at BIST start.
REQ-014 The block SHALL have port FAULT_INJ, input, 1 bit: DFT hook; when 1, bit 0 of read data from FI_ADDR is inverted.
REQ-015 The block SHALL have port ODATA, output, DW bits: read data.
REQ-016 The block SHALL have port BIST_PASS, output, 1 bit: BIST result.
REQ-017 The block SHALL have port BIST_DONE, output, 1 bit: BIST complete.
REQ-018 The block SHALL have port BIST_FAIL_ADDR, output, AW bits: first failing address.

Function
REQ-019 A command SHALL be the CLK edge where CE=1 and the registered CE was 0; CSB, WEB, ADDR and IDATA are captured on that edge.
REQ-020 A command with CSB=0 and WEB=0 SHALL write IDATA to ADDR; the write is visible to a read issued one cycle later.
REQ-021 A command with CSB=0 and WEB=1 SHALL read ADDR; the read word is registered into the ODATA holding register 2 CLK after the command edge.
REQ-022 ODATA SHALL equal the holding register while OEB=0, and all zeros while OEB=1; the holding register itself is unaffected by OEB.
REQ-023 A command with CSB=1 SHALL be ignored; a CE held high SHALL issue only one command.
REQ-024 The FSM states SHALL be IDLE, HWR, HRD, BRUN and BDONE; IDLE goes to HWR or HRD on a command and to BRUN on a BIST_EN rise; HWR and HRD return to IDLE.
REQ-025 A BIST_EN rise coinciding with a host command SHALL give BIST priority and drop the command.
REQ-026 Host commands in BRUN or BDONE SHALL be dropped.
REQ-027 BIST modes SHALL be: 0 March C- (10N ops); 1 MATS+ (5N); 2 checkerboard 0x55../0xAA.. write-then-read (4N); 3 solid all-0 then all-1 (4N).
REQ-028 BIST_MODE 4-7 SHALL be reserved and SHALL go directly to BDONE with PASS=0 and FAIL_ADDR=0.
REQ-029 BIST SHALL perform one memory op per cycle, with the read compare pipelined one cycle behind; BIST_DONE SHALL assert within ops+4 cycles of the BIST_EN rise.
REQ-030 The address counter SHALL wrap 2^AW-1 to 0 (up) and 0 to 2^AW-1 (down) exactly at element boundaries, with no extra op.
REQ-031 On the first mismatch, BIST_FAIL_ADDR SHALL latch the failing address; later mismatches SHALL not update it, and the run continues to completion.
REQ-032 In BDONE, BIST_DONE=1 and BIST_PASS=(no mismatch); both SHALL hold until BIST_EN falls, then the FSM returns to IDLE with DONE and PASS cleared.
REQ-033 BIST_EN falling during BRUN SHALL abort to IDLE with DONE=0, PASS=0 and memory contents undefined.
REQ-034 BIST_PASS SHALL be 0 at all times outside BDONE.

Reset
REQ-035 RSTN=0 SHALL immediately clear the FSM to IDLE and set ODATA, the holding register, BIST_PASS, BIST_DONE, BIST_FAIL_ADDR and the CE/BIST_EN edge registers to 0, including mid-command or mid-BIST.
REQ-036 Memory array contents SHALL not be reset.

Structure
REQ-037 A shared package memctrl_pkg SHALL hold the FSM state enum, the BIST mode codes, the march element/op encoding and the checkerboard constants.
REQ-038 The storage SHALL be a sub-module memctrl_sram: single-port, 2^AW x DW, synchronous read with 1-cycle latency, no reset.

Verification (AW=4, DW=8)
REQ-039 Write 0xA5 to 0x3, then read 0x3 with OEB=0 -> ODATA=0xA5 at command+2 CLK; setting OEB=1 -> ODATA=0x00.
REQ-040 Write 0x11 to 0xF and 0x22 to 0x0, then read both -> 0x11 and 0x22; a command with CSB=1 and WEB=0 to 0x0 -> no change.
REQ-041 BIST_EN rise with MODE=0 and FAULT_INJ=0 -> DONE=1 and PASS=1 within 164 cycles; BIST_EN low -> DONE=0 and PASS=0.
REQ-042 MODE=1 with FAULT_INJ=1 and FI_ADDR=0x9 -> DONE=1, PASS=0, FAIL_ADDR=0x9.
REQ-043 MODE=5 -> DONE=1, PASS=0 within 4 cycles; a host read issued during BRUN -> ODATA unchanged.
REQ-044 RSTN pulsed low mid-BIST -> all outputs 0 asynchronously; the next host write/read -> correct data.
